clk_ce_reset_gen: RTL and testbench
===================================

# clk_ce_reset_gen

Sits directly downstream of the system PLL and turns its 49.152 MHz output and `locked` flag into everything the Bosconian core needs to run from one clock. It synchronizes `locked`, holds the core in reset until the PLL has been stable for a programmable time, and then releases it. It also generates the single-cycle clock enables that replace the arcade's divided clocks: 6.144 MHz pixel, 3.072 MHz CPU (two phases) and 1.536 MHz sound. A glitch-free pause input gates the CPU and sound enables.

## Interface
- `LOCK_HOLD`, default 1024: cycles `locked` must stay high before `core_reset` releases; legal range 1..65535.
- `clk_sys` in 1: 49.152 MHz PLL output; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock flag; asynchronous to `clk_sys`.
- `pause` in 1: level; 1 freezes CPU and sound enables.
- `core_reset` out 1: synchronous active-high reset for the core.
- `ce_pix` out 1: 1-cycle pulse every 8 clocks.
- `ce_cpu` out 1: 1-cycle pulse every 16 clocks, rising-phase.
- `ce_cpu_n` out 1: 1-cycle pulse every 16 clocks, 8 clocks after `ce_cpu`.
- `ce_snd` out 1: 1-cycle pulse every 32 clocks.

## Operation
- Lock synchronizer: `pll_locked` passes through two flops (`lk1`, `lk2`). The state machine uses only `lk2`.
- States:
  - WAIT_LOCK (reset state): `core_reset`=1; hold counter=0; divider=0.
  - WAIT_LOCK → HOLD when `lk2`=1.
  - HOLD: `core_reset`=1; hold counter increments; divider runs.
  - HOLD → RUN when the hold counter = `LOCK_HOLD`-1.
  - RUN: `core_reset`=0; divider runs.
  - HOLD or RUN → WAIT_LOCK whenever `lk2`=0. This takes priority over the HOLD → RUN transition in the same cycle.
- `rst`=1 forces WAIT_LOCK. It also clears the sync flops, the divider, the hold counter, the pause latch and all outputs, taking priority over everything else.
- Divider: 5-bit `div`. It is cleared in WAIT_LOCK and increments by 1 every cycle in HOLD and RUN, wrapping 31 → 0.
- Enables are registered and asserted in the cycle after `div` matches:
  - `ce_pix`: `div[2:0]`=7.
  - `ce_cpu`: `div[3:0]`=15 and `pause_q`=0.
  - `ce_cpu_n`: `div[3:0]`=7 and `pause_q`=0.
  - `ce_snd`: `div`=31 and `pause_q`=0.
- Enables also pulse during HOLD, so the core's synchronous reset sees clock enables.
- Pause latch: `pause_q` loads `pause` only in cycles where `div[3:0]`=15. Pause therefore starts and ends on a whole CPU period, and no `ce_cpu_n` is ever emitted without its preceding `ce_cpu`. `ce_pix` is never gated.
- Hold counter: 16 bits, saturating; it cannot wrap because it exits at `LOCK_HOLD`-1.

## Timing
- After `rst`, all outputs = 0 except `core_reset`, which = 1 in the first cycle after `rst`.
- `pll_locked` first sampled high at edge t:
  - `lk2`=1 at t+1.
  - State = HOLD from t+2.
  - State = RUN from t+2+`LOCK_HOLD`.
  - `core_reset` falls at edge t+2+`LOCK_HOLD`.
- First enables, with k = first HOLD cycle (`div`=0): `ce_pix` first high at k+8, `ce_cpu_n` at k+8, `ce_cpu` at k+16, `ce_snd` at k+32.
- Loss of lock: `pll_locked` sampled low at edge u gives state WAIT_LOCK and `core_reset`=1 from u+2. Enables stop at the same edge, with at most one pulse already registered completing.
- A `pll_locked` glitch shorter than one cycle may be missed; one lasting ≥2 cycles always restarts the full HOLD period.
- Pause latency: `pause` rising 1..16 cycles before a `div[3:0]`=15 cycle suppresses the `ce_cpu` pulse due one cycle after that match, and all later ones. Release is symmetric.
- Pulse widths: every enable is exactly 1 cycle. `ce_cpu` and `ce_cpu_n` are never high together.

## Test plan
- Power-up: `rst`=1 for 3 cycles, `pll_locked`=0. Expect `core_reset`=1 and all ce=0 for 100 cycles.
- Lock sequence, `LOCK_HOLD`=16: `pll_locked` rises at edge 10. Expect HOLD at 12, first `ce_pix` at 20, `core_reset` falling at 28, then `ce_pix` period 8, `ce_cpu` period 16, `ce_snd` period 32.
- Phase check over 256 RUN cycles:
  - `ce_cpu_n` always 8 cycles after `ce_cpu`; never coincident.
  - Every `ce_cpu` coincides with a `ce_pix`.
  - Pulse counts: `ce_pix`=32, `ce_cpu`=16, `ce_cpu_n`=16, `ce_snd`=8.
- Pause: assert `pause` mid-period for 40 cycles. Expect `ce_cpu`, `ce_cpu_n` and `ce_snd` to stop and restart only on 16-cycle boundaries, with no orphan `ce_cpu_n` and `ce_pix` uninterrupted.
- Lock loss: drop `pll_locked` for 3 cycles in RUN. Expect `core_reset`=1 two cycles after the drop, enables cleared, and a full 16-cycle HOLD after relock before `core_reset` falls.
- Reset mid-HOLD: `rst` pulsed at HOLD count 9 while `pll_locked` stays 1. Expect WAIT_LOCK, a fresh 2-cycle sync plus 16-cycle HOLD, and `div` restarting at 0.

Source files
------------

// File: rtl/clk_ce_reset_gen.sv
// Core reset sequencer and clock-enable generator driven from the 49.152 MHz PLL clock.
// Holds the core in reset until the PLL lock has been stable, then derives pixel/CPU/sound enables.
module clk_ce_reset_gen #(
  parameter int unsigned LOCK_HOLD = 1024
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_cpu_n,
  output logic ce_snd
);

  localparam logic [15:0] HOLD_LAST = 16'(LOCK_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        lk1_reg, lk2_reg;
  logic [4:0]  div_reg, div_next;
  logic [15:0] hold_cnt_reg, hold_cnt_next;
  logic        pause_q_reg, pause_q_next;
  logic        core_reset_reg, core_reset_next;
  logic        ce_pix_reg, ce_pix_next;
  logic        ce_cpu_reg, ce_cpu_next;
  logic        ce_cpu_n_reg, ce_cpu_n_next;
  logic        ce_snd_reg, ce_snd_next;
  logic        cpu_slot;
  logic        ce_gate;

  assign cpu_slot = (div_reg[3:0] == 4'hF);
  // Losing lk2 kills enables on the same edge the state falls back to WAIT_LOCK.
  assign ce_gate  = (state_reg != WAIT_LOCK) && lk2_reg;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      lk1_reg        <= 1'b0;
      lk2_reg        <= 1'b0;
      state_reg      <= WAIT_LOCK;
      div_reg        <= 5'd0;
      hold_cnt_reg   <= 16'd0;
      pause_q_reg    <= 1'b0;
      core_reset_reg <= 1'b1;
      ce_pix_reg     <= 1'b0;
      ce_cpu_reg     <= 1'b0;
      ce_cpu_n_reg   <= 1'b0;
      ce_snd_reg     <= 1'b0;
    end else begin
      lk1_reg        <= pll_locked;
      lk2_reg        <= lk1_reg;
      state_reg      <= state_next;
      div_reg        <= div_next;
      hold_cnt_reg   <= hold_cnt_next;
      pause_q_reg    <= pause_q_next;
      core_reset_reg <= core_reset_next;
      ce_pix_reg     <= ce_pix_next;
      ce_cpu_reg     <= ce_cpu_next;
      ce_cpu_n_reg   <= ce_cpu_n_next;
      ce_snd_reg     <= ce_snd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    hold_cnt_next = hold_cnt_reg;
    pause_q_next  = pause_q_reg;

    case (state_reg)
      WAIT_LOCK: begin
        div_next      = 5'd0;
        hold_cnt_next = 16'd0;
        if (lk2_reg) state_next = HOLD;
      end
      HOLD: begin
        div_next = div_reg + 5'd1;
        if (hold_cnt_reg != 16'hFFFF) hold_cnt_next = hold_cnt_reg + 16'd1;
        if (!lk2_reg) begin
          state_next = WAIT_LOCK;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        div_next      = div_reg + 5'd1;
        hold_cnt_next = 16'd0;
        if (!lk2_reg) state_next = WAIT_LOCK;
      end
      default: begin
        state_next    = WAIT_LOCK;
        div_next      = 5'd0;
        hold_cnt_next = 16'd0;
      end
    endcase

    // Pause is only taken on a CPU-period boundary, and the freshly sampled value
    // already governs the ce_cpu pulse registered on that same boundary.
    if (cpu_slot) pause_q_next = pause;

    core_reset_next = (state_next != RUN);
    ce_pix_next     = ce_gate && (div_reg[2:0] == 3'd7);
    ce_cpu_next     = ce_gate && cpu_slot && !pause_q_next;
    ce_cpu_n_next   = ce_gate && (div_reg[3:0] == 4'd7) && !pause_q_next;
    ce_snd_next     = ce_gate && (div_reg == 5'd31) && !pause_q_next;
  end

  assign core_reset = core_reset_reg;
  assign ce_pix     = ce_pix_reg;
  assign ce_cpu     = ce_cpu_reg;
  assign ce_cpu_n   = ce_cpu_n_reg;
  assign ce_snd     = ce_snd_reg;

endmodule

// File: tb/tb_clk_ce_reset_gen.sv
// Directed bench for clk_ce_reset_gen with LOCK_HOLD=16: power-up, lock, phase,
// pause, lock loss and reset-in-HOLD sequences with hand-computed edge positions.
module tb_clk_ce_reset_gen;

  localparam int unsigned LOCK_HOLD = 16;

  logic clk_sys = 1'b0;
  logic rst, pll_locked, pause;
  logic core_reset, ce_pix, ce_cpu, ce_cpu_n, ce_snd;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int last_pix = -1, last_cpu = -1, last_snd = -1;
  int n_pix, n_cpu, n_cpu_n, n_snd;
  int gap_err, phase_err;
  bit steady = 1'b0;
  bit gap_cpu_en = 1'b1;

  clk_ce_reset_gen #(.LOCK_HOLD(LOCK_HOLD)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pause      (pause),
    .core_reset (core_reset),
    .ce_pix     (ce_pix),
    .ce_cpu     (ce_cpu),
    .ce_cpu_n   (ce_cpu_n),
    .ce_snd     (ce_snd)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] ce_bits();
    return {ce_pix, ce_cpu, ce_cpu_n, ce_snd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-18s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic reset_stats();
    n_pix = 0; n_cpu = 0; n_cpu_n = 0; n_snd = 0;
    gap_err = 0; phase_err = 0;
  endtask

  // One clock edge, then sample outputs 1 time unit later and update pulse statistics.
  task automatic tick_obs();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (steady) begin
      if (ce_cpu === 1'b1 && ce_cpu_n === 1'b1) phase_err++;
      if (ce_cpu === 1'b1 && ce_pix !== 1'b1) phase_err++;
      if (ce_cpu_n === 1'b1 && (last_cpu < 0 || cyc - last_cpu != 8)) phase_err++;
      if (core_reset !== 1'b0) phase_err++;
      if (ce_pix === 1'b1 && last_pix >= 0 && cyc - last_pix != 8) gap_err++;
      if (gap_cpu_en) begin
        if (ce_cpu === 1'b1 && last_cpu >= 0 && cyc - last_cpu != 16) gap_err++;
        if (ce_snd === 1'b1 && last_snd >= 0 && cyc - last_snd != 32) gap_err++;
      end
    end
    if (ce_pix === 1'b1)   begin n_pix++;   last_pix = cyc; end
    if (ce_cpu === 1'b1)   begin n_cpu++;   last_cpu = cyc; end
    if (ce_cpu_n === 1'b1) n_cpu_n++;
    if (ce_snd === 1'b1)   begin n_snd++;   last_snd = cyc; end
  endtask

  initial begin
    int bad, f_pix, f_cpu, f_cpu_n, f_snd, f_rel, cr_pre, found, exp_cr;

    rst = 1'b1; pll_locked = 1'b0; pause = 1'b0;
    reset_stats();

    // Power-up
    tick_obs();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ce", ce_bits(), 0);
    tick_obs(); tick_obs();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick_obs();
      if (core_reset !== 1'b1 || ce_bits() !== 4'd0) bad++;
    end
    chk("pwrup_hold", bad, 0);

    // Lock: pll_locked sampled high at relative edge 0
    pll_locked = 1'b1;
    f_pix = -1; f_cpu = -1; f_cpu_n = -1; f_snd = -1; f_rel = -1; cr_pre = 0;
    for (int n = 0; n < 40; n++) begin
      tick_obs();
      if (ce_pix === 1'b1 && f_pix < 0) f_pix = n;
      if (ce_cpu === 1'b1 && f_cpu < 0) f_cpu = n;
      if (ce_cpu_n === 1'b1 && f_cpu_n < 0) f_cpu_n = n;
      if (ce_snd === 1'b1 && f_snd < 0) f_snd = n;
      if (core_reset === 1'b0 && f_rel < 0) f_rel = n;
      if (n == 17) cr_pre = int'(core_reset);
    end
    chk("lock_first_pix", f_pix, 10);
    chk("lock_first_cpu_n", f_cpu_n, 10);
    chk("lock_first_cpu", f_cpu, 18);
    chk("lock_first_snd", f_snd, 34);
    chk("lock_rst_fall", f_rel, 18);
    chk("lock_rst_before", cr_pre, 1);

    // Phase check over 256 RUN cycles
    reset_stats();
    steady = 1'b1;
    gap_cpu_en = 1'b1;
    for (int i = 0; i < 256; i++) tick_obs();
    chk("phase_n_pix", n_pix, 32);
    chk("phase_n_cpu", n_cpu, 16);
    chk("phase_n_cpu_n", n_cpu_n, 16);
    chk("phase_n_snd", n_snd, 8);
    chk("phase_err", phase_err, 0);
    chk("phase_gap_err", gap_err, 0);

    // Pause: align on ce_snd (div=0 afterwards), move to div=4, then pause for 40 edges
    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      tick_obs();
      if (ce_snd === 1'b1) found = 1;
    end
    chk("pause_sync_found", found, 1);
    repeat (4) tick_obs();
    reset_stats();
    gap_cpu_en = 1'b0;
    pause = 1'b1;
    f_cpu = -1;
    for (int j = 1; j <= 64; j++) begin
      tick_obs();
      if (ce_cpu === 1'b1 && f_cpu < 0) f_cpu = j;
      if (j == 40) pause = 1'b0;
    end
    chk("pause_n_pix", n_pix, 8);
    chk("pause_n_cpu", n_cpu, 2);
    chk("pause_n_cpu_n", n_cpu_n, 2);
    chk("pause_n_snd", n_snd, 1);
    chk("pause_first_cpu", f_cpu, 44);
    chk("pause_phase_err", phase_err, 0);
    chk("pause_pix_gap", gap_err, 0);
    steady = 1'b0;

    // Lock loss: pll_locked low at relative edges 0..2, high again from edge 3
    pll_locked = 1'b0;
    bad = 0; exp_cr = 0; f_pix = -1; cr_pre = 0;
    for (int m = 0; m <= 24; m++) begin
      tick_obs();
      exp_cr = (m >= 2 && m < 21) ? 1 : 0;
      if (int'(core_reset) !== exp_cr) cr_pre++;
      if (m >= 2 && m <= 12 && ce_bits() !== 4'd0) bad++;
      if (m >= 2 && ce_pix === 1'b1 && f_pix < 0) f_pix = m;
      if (m == 2) pll_locked = 1'b1;
    end
    chk("loss_core_reset", cr_pre, 0);
    chk("loss_ce_cleared", bad, 0);
    chk("loss_first_pix", f_pix, 13);

    // Reset pulse while in HOLD with hold count 9
    rst = 1'b1;
    tick_obs();
    chk("rst_run_core_reset", core_reset, 1);
    chk("rst_run_ce", ce_bits(), 0);
    rst = 1'b0;
    bad = 0; found = 0;
    for (int i = 1; i <= 12; i++) begin
      tick_obs();
      if (core_reset !== 1'b1) bad++;
      if (i == 11) found = int'(ce_pix);
    end
    chk("hold_core_reset", bad, 0);
    chk("hold_ce_pix", found, 1);
    rst = 1'b1;
    tick_obs();
    chk("rst_hold_core_reset", core_reset, 1);
    chk("rst_hold_ce", ce_bits(), 0);
    rst = 1'b0;
    f_pix = -1; f_cpu = -1; f_rel = -1; cr_pre = 0;
    for (int p = 1; p <= 24; p++) begin
      tick_obs();
      if (ce_pix === 1'b1 && f_pix < 0) f_pix = p;
      if (ce_cpu === 1'b1 && f_cpu < 0) f_cpu = p;
      if (core_reset === 1'b0 && f_rel < 0) f_rel = p;
      if (p == 18) cr_pre = int'(core_reset);
    end
    chk("rehold_first_pix", f_pix, 11);
    chk("rehold_first_cpu", f_cpu, 19);
    chk("rehold_rst_fall", f_rel, 19);
    chk("rehold_rst_before", cr_pre, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
